// File: rtl/ulpi_pkg.sv
// ULPI shared encodings: RX CMD fields, linestates and TX CMD prefixes.
// Imported by the RX decoder, the TX/register block and the chirp detector.
package ulpi_pkg;

  typedef enum logic [1:0] {
    RXEV_NONE       = 2'b00,
    RXEV_ACTIVE     = 2'b01,
    RXEV_DISCONNECT = 2'b10,
    RXEV_ERROR      = 2'b11
  } rxev_t;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } ls_t;

  // TX CMD byte bits [7:6]
  localparam logic [1:0] TXCMD_SPECIAL  = 2'b00;
  localparam logic [1:0] TXCMD_TRANSMIT = 2'b01;
  localparam logic [1:0] TXCMD_REGWR    = 2'b10;
  localparam logic [1:0] TXCMD_REGRD    = 2'b11;

  function automatic rxev_t rxcmd_event(input logic [7:0] b);
    return rxev_t'(b[5:4]);
  endfunction

endpackage

// File: rtl/ulpi_ls_debounce.sv
// Linestate stability timer: counts cycles since the last linestate
// change and flags when the hold time has been reached.
module ulpi_ls_debounce #(
  parameter int STABLE_CYCLES = 150,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic stable
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STABLE_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clear)
      cnt_nxt = '0;
    else if (cnt != LIMIT)
      cnt_nxt = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      stable <= (cnt_nxt == LIMIT);
    end
  end

endmodule

// File: rtl/ulpi_rx_decoder.sv
// ULPI receive front end: bus turnaround tracking, RX CMD decode
// and framing of received packet bytes.
module ulpi_rx_decoder
  import ulpi_pkg::*;
#(
  parameter int LS_STABLE_CYCLES = 150,
  parameter int LS_CNT_W         = 16
) (
  input  logic       USB_CLKIN,
  input  logic       RST,
  input  logic [7:0] USB_DATA_IN,
  input  logic       USB_DIR,
  input  logic       USB_NXT,
  output logic       BUS_OWNED,
  output logic [1:0] LINESTATE,
  output logic [1:0] VBUS_STATE,
  output logic       RX_ACTIVE,
  output logic       RX_ERROR,
  output logic       HOST_DISCONNECT,
  output logic       RXCMD_STB,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_SOP,
  output logic       RX_EOP,
  output logic       LINESTATE_STABLE
);

  logic  dir_q;
  logic  turn;
  logic  is_cmd;
  logic  is_byte;
  logic  pkt_byte;
  logic  act_nxt;
  logic  rise;
  logic  fall;
  logic  first_q;
  logic  got_q;
  logic  ls_chg;
  rxev_t ev;

  assign turn     = USB_DIR != dir_q;
  assign is_cmd   = USB_DIR && !USB_NXT && !turn;
  assign is_byte  = USB_DIR && USB_NXT && !turn;
  assign pkt_byte = is_byte && RX_ACTIVE;
  assign ev       = rxcmd_event(USB_DATA_IN);
  assign ls_chg   = is_cmd && (USB_DATA_IN[1:0] != LINESTATE);

  // NXT on the rising turnaround is the PHY's early receive start
  always_comb begin
    act_nxt = RX_ACTIVE;
    unique case (1'b1)
      turn && USB_DIR:  act_nxt = RX_ACTIVE || USB_NXT;
      turn && !USB_DIR: act_nxt = 1'b0;
      is_cmd:           act_nxt = ev inside {RXEV_ACTIVE, RXEV_ERROR};
      default: ;
    endcase
  end

  assign rise = act_nxt && !RX_ACTIVE;
  assign fall = !act_nxt && RX_ACTIVE;

  always_ff @(posedge USB_CLKIN) begin
    if (RST) begin
      dir_q           <= 1'b0;
      BUS_OWNED       <= 1'b0;
      LINESTATE       <= LS_J;
      VBUS_STATE      <= 2'b00;
      RX_ACTIVE       <= 1'b0;
      RX_ERROR        <= 1'b0;
      HOST_DISCONNECT <= 1'b0;
      RXCMD_STB       <= 1'b0;
      RX_DATA         <= 8'h00;
      RX_VALID        <= 1'b0;
      RX_SOP          <= 1'b0;
      RX_EOP          <= 1'b0;
      first_q         <= 1'b0;
      got_q           <= 1'b0;
    end else begin
      dir_q     <= USB_DIR;
      BUS_OWNED <= USB_DIR && dir_q;
      RX_ACTIVE <= act_nxt;
      RXCMD_STB <= is_cmd;
      RX_VALID  <= is_byte;
      RX_SOP    <= pkt_byte && first_q;
      RX_EOP    <= fall && got_q;
      if (is_byte)
        RX_DATA <= USB_DATA_IN;
      if (is_cmd) begin
        LINESTATE       <= USB_DATA_IN[1:0];
        VBUS_STATE      <= USB_DATA_IN[3:2];
        HOST_DISCONNECT <= (ev == RXEV_DISCONNECT);
      end
      if (rise)
        first_q <= 1'b1;
      else if (pkt_byte)
        first_q <= 1'b0;
      if (rise || fall)
        got_q <= 1'b0;
      else if (pkt_byte)
        got_q <= 1'b1;
      // error is sticky across EOP and only a new packet clears it
      if (pkt_byte && first_q)
        RX_ERROR <= 1'b0;
      else if ((is_byte && !RX_ACTIVE) || (is_cmd && ev == RXEV_ERROR))
        RX_ERROR <= 1'b1;
    end
  end

  ulpi_ls_debounce #(
    .STABLE_CYCLES(LS_STABLE_CYCLES),
    .CNT_W        (LS_CNT_W)
  ) u_debounce (
    .clk   (USB_CLKIN),
    .rst   (RST),
    .clear (ls_chg),
    .stable(LINESTATE_STABLE)
  );

endmodule
